// File: rtl/seven_seg_if.sv
// Signal bundle between the display scan controller and its host/decoder side.
// LOAD is a single-cycle strobe with no ready: whatever VALUE holds on a LOAD cycle is taken.
`timescale 1ns/1ps
interface seven_seg_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    ENABLE;
  logic [4*NUM_DIGITS-1:0] VALUE;
  logic                    LOAD;
  logic                    LZ_SUPPRESS;
  logic [3:0]              BIN_OUT;
  logic [0:6]              SEV_IN;
  logic [0:6]              SEG;
  logic [NUM_DIGITS-1:0]   AN;
  logic                    FRAME_START;
  logic [1:0]              DBG_STATE;

  modport master (
    output ENABLE, VALUE, LOAD, LZ_SUPPRESS, SEV_IN,
    input  BIN_OUT, SEG, AN, FRAME_START, DBG_STATE
  );

  modport slave (
    input  ENABLE, VALUE, LOAD, LZ_SUPPRESS, SEV_IN,
    output BIN_OUT, SEG, AN, FRAME_START, DBG_STATE
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment scanner sharing one external decoder,
// with frame-synchronous value commit, inter-digit blanking and leading-zero blanking.
`timescale 1ns/1ps
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 100
) (
  input logic       CLK,
  input logic       RST_N,
  seven_seg_if.slave bus
);
  localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW   = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] DC_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BC_LAST  = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [VW-1:0]       pending_q, pending_d;
  logic [VW-1:0]       disp_q, disp_d;
  logic                run_q, run_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [0:6]          seg_q, seg_d;
  logic                fs_q, fs_d;
  logic [NUM_DIGITS-1:0] lit;
  logic                upper_zero;
  logic [3:0]          bin;

  // run_q is low until the first frame has been committed after reset or re-enable.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= BLANK;
      idx_q     <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
      disp_q    <= '0;
      run_q     <= 1'b0;
      an_q      <= '1;
      seg_q     <= '1;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      disp_q    <= disp_d;
      run_q     <= run_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      fs_q      <= fs_d;
    end
  end

  always_comb begin
    bin = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) bin = disp_q[4*i +: 4];
    end
  end

  // A digit is lit unless it and every more significant digit are zero.
  always_comb begin
    lit        = '1;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (disp_q[4*i +: 4] == 4'd0);
      lit[i]     = (i == 0) || !bus.LZ_SUPPRESS || !upper_zero;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    disp_d    = disp_q;
    fs_d      = 1'b0;
    pending_d = bus.LOAD ? bus.VALUE : pending_q;
    an_d      = '1;
    seg_d     = '1;

    if (!bus.ENABLE) begin
      state_d = BLANK;
      idx_d   = '0;
      cnt_d   = '0;
      run_d   = 1'b0;
    end else if (!run_q ||
                 (state_q == SHOW && cnt_q == DC_LAST && idx_q == IDX_LAST)) begin
      // Commit: the next cycle opens a frame on the new value.
      state_d = BLANK;
      idx_d   = '0;
      cnt_d   = '0;
      run_d   = 1'b1;
      disp_d  = bus.LOAD ? bus.VALUE : pending_q;
      fs_d    = 1'b1;
    end else if (state_q == BLANK) begin
      if (cnt_q == BC_LAST) begin
        state_d = SHOW;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      if (cnt_q == DC_LAST) begin
        state_d = BLANK;
        cnt_d   = '0;
        idx_d   = idx_q + IW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // idx is unchanged across BLANK->SHOW, so SEV_IN already decodes this digit.
    if (state_d == SHOW && lit[idx_d]) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_d);
      seg_d = bus.SEV_IN;
    end
  end

  assign bus.BIN_OUT     = bin;
  assign bus.SEG         = seg_q;
  assign bus.AN          = an_q;
  assign bus.FRAME_START = fs_q;
  assign bus.DBG_STATE   = {run_q, state_q == SHOW};
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: frame-by-frame scoreboard of AN/SEG/BIN_OUT/FRAME_START
// driven from a vector table, hand sequences for enable/reset corners, then random frames.
`timescale 1ns/1ps
module tb_seven_seg_scanner;
  localparam int ND = 4;
  localparam int DC = 4;
  localparam int BC = 1;
  localparam int FL = ND * (DC + BC);

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  seven_seg_if #(.NUM_DIGITS(ND)) bus();

  seven_seg_scanner #(
    .NUM_DIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Stand-in for the external decoder: active-low a..g, a in the leftmost bit.
  function automatic logic [0:6] dec(input logic [3:0] n);
    case (n)
      4'h0: dec = 7'b0000001; 4'h1: dec = 7'b1001111;
      4'h2: dec = 7'b0010010; 4'h3: dec = 7'b0000110;
      4'h4: dec = 7'b1001100; 4'h5: dec = 7'b0100100;
      4'h6: dec = 7'b0100000; 4'h7: dec = 7'b0001111;
      4'h8: dec = 7'b0000000; 4'h9: dec = 7'b0000100;
      4'hA: dec = 7'b0001000; 4'hB: dec = 7'b1100000;
      4'hC: dec = 7'b0110001; 4'hD: dec = 7'b1000010;
      4'hE: dec = 7'b0110000; default: dec = 7'b0111000;
    endcase
  endfunction

  assign bus.SEV_IN = dec(bus.BIN_OUT);

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] value;
    logic        lz;
    logic [3:0]  lit;
  } vec_t;
  vec_t vecs[9];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] obs();
    return {bus.FRAME_START, bus.AN, bus.SEG, bus.BIN_OUT};
  endfunction

  function automatic logic [3:0] lz_model(input logic [15:0] v, input logic lz);
    int h = 0;
    logic [3:0] r = '0;
    if (!lz) return 4'hF;
    for (int i = 1; i < ND; i++) if (v[4*i +: 4] != 4'h0) h = i;
    for (int i = 0; i <= h; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Entered on the first cycle of a frame; leaves on the first cycle of the next.
  task automatic check_frame(input string tag, input logic [15:0] val, input logic lz,
                             input logic [3:0] lit, input int lc1, input logic [15:0] lv1,
                             input int lc2, input logic [15:0] lv2);
    logic [3:0]  nib;
    logic [3:0]  an_on;
    logic [15:0] e;
    bus.LZ_SUPPRESS = lz;
    for (int d = 0; d < ND; d++) begin
      nib   = val[4*d +: 4];
      an_on = 4'b0001 << d;
      an_on = ~an_on;
      exp_q.push_back({(d == 0), 4'hF, 7'h7F, nib});
      for (int k = 0; k < DC; k++)
        exp_q.push_back({1'b0, lit[d] ? an_on : 4'hF, lit[d] ? dec(nib) : 7'h7F, nib});
    end
    for (int c = 0; c < FL; c++) begin
      bus.LOAD  = (c == lc1) || (c == lc2);
      bus.VALUE = (c == lc2) ? lv2 : lv1;
      e = exp_q.pop_front();
      check($sformatf("%s c=%0d", tag, c), {16'h0, obs()}, {16'h0, e});
      tick();
    end
    bus.LOAD = 1'b0;
  endtask

  initial begin
    logic [15:0] cur;
    logic [15:0] lv;
    logic        lz;
    logic        do_load;
    int          lc;
    int          nz;

    vecs[0] = '{16'h1234, 1'b0, 4'b1111};
    vecs[1] = '{16'h1234, 1'b1, 4'b1111};
    vecs[2] = '{16'h0050, 1'b1, 4'b0011};
    vecs[3] = '{16'h0000, 1'b1, 4'b0001};
    vecs[4] = '{16'h0000, 1'b0, 4'b1111};
    vecs[5] = '{16'h00F0, 1'b1, 4'b0011};
    vecs[6] = '{16'h0100, 1'b1, 4'b0111};
    vecs[7] = '{16'hABCD, 1'b1, 4'b1111};
    vecs[8] = '{16'h8000, 1'b1, 4'b1111};

    bus.ENABLE      = 1'b1;
    bus.LOAD        = 1'b0;
    bus.VALUE       = '0;
    bus.LZ_SUPPRESS = 1'b0;
    RST_N           = 1'b0;
    repeat (2) @(posedge CLK);
    #3;
    check("rst AN", {28'h0, bus.AN}, 32'hF);
    check("rst SEG", {25'h0, bus.SEG}, 32'h7F);
    check("rst BIN", {28'h0, bus.BIN_OUT}, 32'h0);
    check("rst FS", {31'h0, bus.FRAME_START}, 32'h0);
    check("rst DBG", {30'h0, bus.DBG_STATE}, 32'h0);

    // LOAD on the very first edge lands in the first frame via the bypass.
    RST_N     = 1'b1;
    bus.LOAD  = 1'b1;
    bus.VALUE = 16'h1234;
    tick();

    for (int i = 0; i < 9; i++) begin
      int nx;
      nx = (i < 8) ? i + 1 : i;
      check_frame($sformatf("vec%0d", i), vecs[i].value, vecs[i].lz, vecs[i].lit,
                  (i < 8) ? 5 : -1, vecs[nx].value, -1, 16'h0);
    end

    // Mid-frame LOAD must not tear; a LOAD on the commit edge wins and also updates pending.
    check_frame("tear", 16'h8000, 1'b0, 4'hF, 12, 16'hABCD, 19, 16'h00F0);
    check_frame("bypass", 16'h00F0, 1'b0, 4'hF, -1, 16'h0, -1, 16'h0);
    check_frame("pend", 16'h00F0, 1'b1, 4'b0011, -1, 16'h0, -1, 16'h0);

    // ENABLE dropped in digit 2's SHOW slot for 7 clocks, with a LOAD while dark.
    bus.LZ_SUPPRESS = 1'b0;
    repeat (12) tick();
    check("en pre AN", {28'h0, bus.AN}, 32'hB);
    bus.ENABLE = 1'b0;
    for (int k = 0; k < 7; k++) begin
      bus.LOAD  = (k == 2);
      bus.VALUE = 16'h5A0C;
      tick();
      check($sformatf("en off AN k=%0d", k), {28'h0, bus.AN}, 32'hF);
      check($sformatf("en off SEG k=%0d", k), {25'h0, bus.SEG}, 32'h7F);
      check($sformatf("en off FS k=%0d", k), {31'h0, bus.FRAME_START}, 32'h0);
    end
    bus.LOAD   = 1'b0;
    bus.ENABLE = 1'b1;
    tick();
    check_frame("reen", 16'h5A0C, 1'b0, 4'hF, -1, 16'h0, -1, 16'h0);

    // Asynchronous reset in digit 1's SHOW slot, checked between clock edges.
    bus.LZ_SUPPRESS = 1'b1;
    repeat (7) tick();
    check("arst pre AN", {28'h0, bus.AN}, 32'hD);
    #2;
    RST_N = 1'b0;
    #1;
    check("arst AN", {28'h0, bus.AN}, 32'hF);
    check("arst SEG", {25'h0, bus.SEG}, 32'h7F);
    check("arst BIN", {28'h0, bus.BIN_OUT}, 32'h0);
    check("arst FS", {31'h0, bus.FRAME_START}, 32'h0);
    tick();
    RST_N = 1'b1;
    tick();
    check_frame("post rst", 16'h0000, 1'b1, 4'b0001, -1, 16'h0, -1, 16'h0);

    cur = 16'h0000;
    for (int f = 0; f < 1000; f++) begin
      lz      = 1'($urandom_range(0, 1));
      do_load = ($urandom_range(0, 3) != 0);
      lc      = $urandom_range(0, FL - 1);
      lv      = 16'($urandom);
      nz      = $urandom_range(0, ND);
      for (int j = 0; j < nz; j++) lv[4*(ND-1-j) +: 4] = 4'h0;
      check_frame($sformatf("rnd%0d", f), cur, lz, lz_model(cur, lz),
                  do_load ? lc : -1, lv, -1, 16'h0);
      if (do_load) cur = lv;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
